// File: rtl/trigger_detector.sv
// Edge trigger detector with hysteresis arming, post-trigger holdoff and
// auto-trigger timeout; trigger_req is held until trigger_ack.
//
// state   | meaning
// PRE     | waiting for the sample to leave the hysteresis band (arming)
// ARMED   | armed, waiting for the level crossing
// FIRE    | trigger_req asserted, waiting for trigger_ack
// HOLD    | counting holdoff samples, edges ignored
module trigger_detector #(
  parameter int ADC_W  = 8,
  parameter int HOLD_W = 16,
  parameter int TO_W   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              sample_en,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic [ADC_W-1:0]  level,
  input  logic [ADC_W-1:0]  hyst,
  input  logic              slope,
  input  logic [HOLD_W-1:0] holdoff,
  input  logic [TO_W-1:0]   auto_timeout,
  input  logic              trigger_ack,
  output logic              trigger_req,
  output logic              auto_trig,
  output logic              armed
);

  typedef enum logic [1:0] {
    S_PRE   = 2'd0,
    S_ARMED = 2'd1,
    S_FIRE  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TO_W-1:0]   r_to_ctr;
  logic [TO_W-1:0]   w_to_nxt;
  logic [HOLD_W-1:0] r_hold_ctr;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              r_auto;
  logic              w_auto_nxt;

  logic [ADC_W:0]    w_sum;
  logic [ADC_W-1:0]  w_hi;
  logic [ADC_W-1:0]  w_lo;
  logic              w_arm;
  logic              w_cross;
  logic [TO_W:0]     w_to_inc;
  logic              w_to_hit;
  logic [HOLD_W:0]   w_hold_inc;
  logic              w_hold_done;

  // Saturating thresholds: one extra bit catches the overflow of level + hyst.
  assign w_sum = {1'b0, level} + {1'b0, hyst};
  assign w_hi  = w_sum[ADC_W] ? {ADC_W{1'b1}} : w_sum[ADC_W-1:0];
  assign w_lo  = (level >= hyst) ? (level - hyst) : '0;

  assign w_arm   = slope ? (adc_data >= w_hi) : (adc_data <= w_lo);
  assign w_cross = slope ? (adc_data <= level) : (adc_data >= level);

  // ">=" rather than "==" keeps the counters bounded if config moves live.
  assign w_to_inc    = {1'b0, r_to_ctr} + 1'b1;
  assign w_to_hit    = (auto_timeout != '0) && (w_to_inc >= {1'b0, auto_timeout});
  assign w_hold_inc  = {1'b0, r_hold_ctr} + 1'b1;
  assign w_hold_done = (w_hold_inc >= {1'b0, holdoff});

  always_comb begin
    w_state_nxt = r_state;
    w_to_nxt    = r_to_ctr;
    w_hold_nxt  = r_hold_ctr;
    w_auto_nxt  = r_auto;

    case (r_state)
      S_PRE: begin
        if (sample_en) begin
          if (w_to_hit) begin
            w_state_nxt = S_FIRE;
            w_auto_nxt  = 1'b1;
            w_to_nxt    = '0;
          end else begin
            w_to_nxt = w_to_inc[TO_W-1:0];
            if (w_arm) w_state_nxt = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        if (sample_en) begin
          if (w_cross) begin
            w_state_nxt = S_FIRE;
            w_auto_nxt  = 1'b0;
            w_to_nxt    = '0;
          end else if (w_to_hit) begin
            w_state_nxt = S_FIRE;
            w_auto_nxt  = 1'b1;
            w_to_nxt    = '0;
          end else begin
            w_to_nxt = w_to_inc[TO_W-1:0];
          end
        end
      end
      S_FIRE: begin
        if (trigger_ack) begin
          w_auto_nxt  = 1'b0;
          w_state_nxt = (holdoff != '0) ? S_HOLD : S_PRE;
        end
      end
      S_HOLD: begin
        if (sample_en) begin
          if (w_hold_done) begin
            w_state_nxt = S_PRE;
            w_hold_nxt  = '0;
          end else begin
            w_hold_nxt = w_hold_inc[HOLD_W-1:0];
          end
        end
      end
      default: begin
        w_state_nxt = S_PRE;
      end
    endcase

    if (!enable) begin
      w_state_nxt = S_PRE;
      w_to_nxt    = '0;
      w_hold_nxt  = '0;
      w_auto_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_PRE;
      r_to_ctr   <= '0;
      r_hold_ctr <= '0;
      r_auto     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_to_ctr   <= w_to_nxt;
      r_hold_ctr <= w_hold_nxt;
      r_auto     <= w_auto_nxt;
    end
  end

  assign trigger_req = (r_state == S_FIRE);
  assign auto_trig   = r_auto;
  assign armed       = (r_state == S_ARMED);

endmodule

// File: tb/tb_trigger_detector.sv
// Scoreboard bench for trigger_detector: directed scenarios plus randomized
// traffic checked against a sample-level behavioural model.
module tb_trigger_detector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        sample_en = 1'b0;
  logic [7:0]  adc_data = '0;
  logic [7:0]  level = 8'd128;
  logic [7:0]  hyst = 8'd8;
  logic        slope = 1'b0;
  logic [15:0] holdoff = '0;
  logic [19:0] auto_timeout = '0;
  logic        trigger_ack = 1'b0;
  logic        trigger_req;
  logic        auto_trig;
  logic        armed;

  trigger_detector #(.ADC_W(8), .HOLD_W(16), .TO_W(20)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_en(sample_en),
    .adc_data(adc_data), .level(level), .hyst(hyst), .slope(slope),
    .holdoff(holdoff), .auto_timeout(auto_timeout), .trigger_ack(trigger_ack),
    .trigger_req(trigger_req), .auto_trig(auto_trig), .armed(armed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int step_id;
    bit auto_f;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   g_step = 0;
  bit   mon_on = 1'b0;
  bit   prev_req = 1'b0;

  // Model view: armed flag, pending request, samples left to ignore,
  // samples seen since the last trigger.
  bit m_armed = 0;
  bit m_req = 0;
  bit m_auto = 0;
  int m_hold_left = 0;
  int m_since = 0;

  function automatic void chk(string name, int act, int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (step %0d)", name, act, exp_v, g_step);
    end
  endfunction

  function automatic void fire(bit is_auto);
    exp_t e;
    m_req = 1; m_auto = is_auto; m_armed = 0; m_since = 0;
    e.step_id = g_step;
    e.auto_f = is_auto;
    exp_q.push_back(e);
  endfunction

  function automatic void model_update();
    int lo, hi, d, lv;
    bit edge_ok, arm_ok;
    lv = int'(level);
    d  = int'(adc_data);
    lo = lv - int'(hyst); if (lo < 0) lo = 0;
    hi = lv + int'(hyst); if (hi > 255) hi = 255;
    if (rst || !enable) begin
      m_armed = 0; m_req = 0; m_auto = 0; m_hold_left = 0; m_since = 0;
    end else if (m_req) begin
      if (trigger_ack) begin
        m_req = 0; m_auto = 0; m_hold_left = int'(holdoff);
      end
    end else if (m_hold_left > 0) begin
      if (sample_en) m_hold_left--;
    end else if (sample_en) begin
      m_since++;
      edge_ok = m_armed && (slope ? (d <= lv) : (d >= lv));
      arm_ok  = slope ? (d >= hi) : (d <= lo);
      if (edge_ok) fire(0);
      else if (auto_timeout != 0 && m_since >= int'(auto_timeout)) fire(1);
      else if (!m_armed && arm_ok) m_armed = 1;
    end
  endfunction

  task automatic step(input bit r, input bit e, input bit s, input int d, input bit a);
    logic [31:0] dv;
    dv = d;
    @(negedge clk);
    rst = r; enable = e; sample_en = s; adc_data = dv[7:0]; trigger_ack = a;
    g_step++;
    model_update();
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic samp(input int d);
    step(0, 1, 1, d, 0);
  endtask

  task automatic ack();
    step(0, 1, 0, 0, 1);
  endtask

  task automatic cfg(input int lv, input int hy, input bit sl, input int ho, input int to);
    step(0, 0, 0, 0, 0);
    level = lv[7:0]; hyst = hy[7:0]; slope = sl;
    holdoff = ho[15:0]; auto_timeout = to[19:0];
    step(0, 0, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_on) begin
      chk("armed", int'(armed), int'(m_armed));
      chk("trigger_req", int'(trigger_req), int'(m_req));
      chk("auto_trig", int'(auto_trig), int'(m_auto));
      if (trigger_req === 1'b1 && !prev_req) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_trigger: got req=1 expected no request (step %0d)", g_step);
        end else begin
          e = exp_q.pop_front();
          chk("trig_step", g_step, e.step_id);
          chk("trig_auto", int'(auto_trig), int'(e.auto_f));
        end
      end
      prev_req = (trigger_req === 1'b1);
    end
  end

  initial begin
    int d, lv, hy;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    mon_on = 1'b1;
    settle();
    chk("reset_req", int'(trigger_req), 0);
    chk("reset_armed", int'(armed), 0);

    // Rising ramp
    cfg(128, 8, 0, 0, 0);
    samp(100); samp(119); settle();
    chk("t1_armed", int'(armed), 1);
    samp(125); samp(130); settle();
    chk("t1_req", int'(trigger_req), 1);
    chk("t1_auto", int'(auto_trig), 0);
    ack(); settle();
    chk("t1_ack_drop", int'(trigger_req), 0);

    // Noise inside the band never arms
    samp(200);
    for (int i = 0; i < 8; i++) begin samp(124); samp(131); end
    settle();
    chk("t2_armed", int'(armed), 0);
    chk("t2_req", int'(trigger_req), 0);
    samp(110); samp(131); settle();
    chk("t2_req_rise", int'(trigger_req), 1);
    ack();

    // Falling edge with held request
    cfg(64, 4, 1, 0, 0);
    samp(80); samp(60); settle();
    chk("t3_req", int'(trigger_req), 1);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
    settle();
    chk("t3_held", int'(trigger_req), 1);
    ack(); settle();
    chk("t3_drop", int'(trigger_req), 0);

    // Holdoff with edges every two samples
    cfg(128, 8, 0, 5, 0);
    for (int i = 0; i < 40; i++) begin
      if (m_req) step(0, 1, 1, (i % 2) ? 131 : 110, 1);
      else samp((i % 2) ? 131 : 110);
    end
    if (m_req) ack();

    // Auto trigger
    cfg(128, 8, 0, 0, 10);
    for (int i = 0; i < 9; i++) samp(50);
    settle();
    chk("t5_not_yet", int'(trigger_req), 0);
    samp(50); settle();
    chk("t5_req", int'(trigger_req), 1);
    chk("t5_auto", int'(auto_trig), 1);
    ack();
    cfg(128, 8, 0, 0, 0);
    for (int i = 0; i < 1000; i++) samp(50);
    settle();
    chk("t5_no_auto", int'(trigger_req), 0);

    // Reset / enable in FIRE, then re-arm required
    samp(110); samp(131);
    step(1, 1, 0, 0, 0); settle();
    chk("t6_rst_req", int'(trigger_req), 0);
    chk("t6_rst_armed", int'(armed), 0);
    samp(110); samp(131);
    step(0, 0, 0, 0, 0); settle();
    chk("t6_en_req", int'(trigger_req), 0);
    samp(131); settle();
    chk("t6_no_rearm", int'(trigger_req), 0);
    samp(110); samp(131); settle();
    chk("t6_rearm_fire", int'(trigger_req), 1);
    ack();

    // Threshold saturation corners
    cfg(0, 5, 0, 0, 0);
    samp(3); samp(1); samp(0); samp(0); samp(7);
    if (m_req) ack();
    cfg(255, 9, 1, 0, 0);
    samp(250); samp(255); samp(200);
    if (m_req) ack();

    // Randomized traffic
    for (int blk = 0; blk < 15; blk++) begin
      lv = (blk % 5 == 0) ? 0 : ((blk % 5 == 1) ? 255 : $urandom_range(0, 255));
      hy = $urandom_range(0, 40);
      cfg(lv, hy, (blk % 5 == 1) ? 1'b1 : 1'($urandom_range(0, 1)),
          $urandom_range(0, 6), ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 40));
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 1) == 0) d = $urandom_range(0, 255);
        else d = lv + $urandom_range(0, 2 * hy + 20) - (hy + 10);
        if (d < 0) d = 0;
        if (d > 255) d = 255;
        step(($urandom_range(0, 199) == 0), ($urandom_range(0, 149) != 0),
             ($urandom_range(0, 3) != 0), d, m_req && ($urandom_range(0, 2) == 0));
      end
    end

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    settle();
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
